// File: rtl/adder_tree_pkg.sv
// Types shared by the adder-tree input collector and the adder-tree benches:
// collector write-FSM states and the frame-length field width.
package adder_tree_pkg;

    typedef enum logic [0:0] {
        COLL_FILL = 1'b0,
        COLL_WAIT = 1'b1
    } coll_state_e;

    // Width of a field that counts 0..n inclusive.
    function automatic int len_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/adder_tree_in_collector.sv
// Serial-to-parallel collector: packs I_DATA_N serial words (or a shorter
// i_last-terminated frame, zero padded) into one parallel frame for the CSA tree.
module adder_tree_in_collector
    import adder_tree_pkg::*;
#(
    parameter  int I_DATA_W = 3,
    parameter  int I_DATA_N = 8,
    localparam int LEN_W    = len_w(I_DATA_N)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [I_DATA_W-1:0]                    i_data,
    input  logic                                   i_valid,
    input  logic                                   i_last,
    output logic                                   o_ready,
    output logic [0:I_DATA_N-1][I_DATA_W-1:0]      o_data,
    output logic [LEN_W-1:0]                       o_len,
    output logic                                   o_valid,
    input  logic                                   i_ready
);

    coll_state_e                              state_q, state_d;
    logic [LEN_W-1:0]                         cnt_q, cnt_d;
    logic [LEN_W-1:0]                         plen_q, plen_d;
    logic [0:I_DATA_N-1][I_DATA_W-1:0]        wbuf_q, wbuf_d;
    logic [0:I_DATA_N-1][I_DATA_W-1:0]        odata_q, odata_d;
    logic [LEN_W-1:0]                         olen_q, olen_d;
    logic                                     ovalid_q, ovalid_d;

    logic                                     accept;
    logic                                     complete;
    logic                                     out_free;
    logic [0:I_DATA_N-1][I_DATA_W-1:0]        wframe;

    // Ready depends only on the state register; reset forces it low in the same cycle.
    assign o_ready  = (state_q == COLL_FILL) && !rst;
    assign accept   = i_valid && o_ready;
    assign complete = accept && ((cnt_q == LEN_W'(I_DATA_N - 1)) || i_last);
    assign out_free = !ovalid_q || i_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        plen_d   = plen_q;
        wbuf_d   = wbuf_q;
        odata_d  = odata_q;
        olen_d   = olen_q;
        ovalid_d = ovalid_q;

        // Write buffer with this cycle's sample merged in; unwritten slots stay zero
        // because the buffer is cleared whenever a frame leaves it.
        wframe = wbuf_q;
        for (int k = 0; k < I_DATA_N; k++) begin
            if (accept && (cnt_q == LEN_W'(k))) wframe[k] = i_data;
        end

        if (ovalid_q && i_ready) ovalid_d = 1'b0;

        case (state_q)
            COLL_FILL: begin
                if (accept) begin
                    wbuf_d = wframe;
                    cnt_d  = cnt_q + LEN_W'(1);
                    if (complete) begin
                        cnt_d = '0;
                        if (out_free) begin
                            odata_d  = wframe;
                            olen_d   = cnt_q + LEN_W'(1);
                            ovalid_d = 1'b1;
                            wbuf_d   = '0;
                        end else begin
                            state_d = COLL_WAIT;
                            plen_d  = cnt_q + LEN_W'(1);
                        end
                    end
                end
            end
            COLL_WAIT: begin
                // Parked frame moves out the same edge the consumer drains the old one.
                if (i_ready) begin
                    odata_d  = wbuf_q;
                    olen_d   = plen_q;
                    ovalid_d = 1'b1;
                    wbuf_d   = '0;
                    plen_d   = '0;
                    state_d  = COLL_FILL;
                end
            end
            default: state_d = COLL_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= COLL_FILL;
            cnt_q    <= '0;
            plen_q   <= '0;
            wbuf_q   <= '0;
            odata_q  <= '0;
            olen_q   <= '0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            plen_q   <= plen_d;
            wbuf_q   <= wbuf_d;
            odata_q  <= odata_d;
            olen_q   <= olen_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign o_data  = odata_q;
    assign o_len   = olen_q;
    assign o_valid = ovalid_q;

endmodule
